wb_write_buffer: RTL and testbench
==================================

Name: wb_write_buffer

Overview:
- Write-side producer for the 4-entry, 16-bit register file.
- Accepts register write-back results from the datapath into a small in-order FIFO.
- Drains one entry per cycle onto the register file's write port (write enable, write address, write data).
- Provides a combinational bypass lookup so decode reads see pending, not-yet-committed values.

Parameters:
- WORD_SIZE, 16, data width of a register value.
- NUM_REGS, 4, number of architectural registers.
- REG_ADDR_W, 2, register address width; must equal log2(NUM_REGS).
- DEPTH, 4, FIFO entries; power of two, minimum 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  write-back request present.
- in_ready  output  1  buffer can accept a request this cycle.
- in_reg  input  REG_ADDR_W  destination register of the request.
- in_data  input  WORD_SIZE  value to write.
- drain_en  input  1  register file write port available this cycle.
- rf_write  output  1  write enable to the register file.
- rf_write_reg  output  REG_ADDR_W  register file write address.
- rf_write_data  output  WORD_SIZE  register file write data.
- q_reg1  input  REG_ADDR_W  bypass query address, port 1.
- q_reg2  input  REG_ADDR_W  bypass query address, port 2.
- q_hit1  output  1  a pending entry targets q_reg1.
- q_data1  output  WORD_SIZE  youngest pending value for q_reg1.
- q_hit2  output  1  a pending entry targets q_reg2.
- q_data2  output  WORD_SIZE  youngest pending value for q_reg2.
- count  output  log2(DEPTH)+1  number of occupied entries.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.

Behaviour:
- Storage:
  - Circular FIFO of {reg, data} entries with head and tail pointers and an occupancy counter.
  - Pointers wrap modulo DEPTH.
- Reset:
  - reset_n low at a rising edge clears head, tail and count to 0; entry contents are don't-care.
  - Resulting outputs: empty=1, full=0, in_ready=1, rf_write=0, q_hit1=q_hit2=0.
  - Reset wins over any same-cycle push or pop, including mid-drain. Pending entries are discarded and are never written to the register file.
- Push:
  - in_ready = !full, combinational. A full buffer does not accept a push even when a pop occurs in the same cycle.
  - Accept occurs when in_valid && in_ready at the rising edge: write the entry at tail, then tail+1.
- Pop:
  - rf_write = !empty && drain_en, combinational.
  - rf_write_reg and rf_write_data always present the head entry. Their values are don't-care when empty.
  - On a rising edge with rf_write=1, the register file commits the write and head advances by 1.
  - Latency: an entry accepted at edge N can reach rf_write at the earliest in the cycle following edge N, committing at edge N+1 when it is at head.
- Simultaneous push and pop: both take effect; count is unchanged.
- count, empty and full are registered, derived from the count register.
- Bypass:
  - Combinational search of occupied entries only.
  - The youngest matching entry (nearest tail) supplies the data.
  - With no match: hit=0 and data=0.
  - The head entry being drained in the current cycle still counts as a match, because the register file has not yet been written.
  - The incoming in_data is not searched.
- Ordering: writes commit strictly in acceptance order, so multiple writes to the same register commit oldest first.

Optional Feature:
- Macro: WB_COALESCE_EN.
- When defined, an accepted push whose in_reg equals the register of the current tail-1 entry overwrites that entry's data instead of allocating a new one. Count, tail and in_ready are unaffected by a coalescing push.
- Coalescing is suppressed when that entry is the head and rf_write=1 in the same cycle; the push then allocates normally.
- With coalescing, a full buffer accepts a push that would coalesce, so in_ready = !full || (in_valid && coalesce_hit).
- When not defined, every accepted push allocates a new entry.

Test Plan:
- Reset then idle -> empty=1, count=0, rf_write=0, in_ready=1, q_hit1=0 regardless of drain_en.
- drain_en=0; push (r1,0x1234), then (r2,0xBEEF) -> count=2; q_reg1=1 gives hit=1, data=0x1234. Set drain_en=1 -> rf_write=1 on two consecutive cycles, carrying r1/0x1234 then r2/0xBEEF; then empty=1.
- drain_en=0; push (r3,0x0001) then (r3,0x0002) -> q_reg1=3 returns 0x0002 (youngest). With the macro undefined, count=2; with it defined, count=1.
- drain_en=0; push 4 entries -> full=1, in_ready=0; a 5th push is not accepted. Then drain_en=1 with push held -> count 4→3; the push is accepted in the following cycle. Tail wrap is verified by the data order r0..r3 followed by the new entry.
- count=2, drain_en=1, push each cycle -> count stays 2 across 6 cycles; the commit order matches the push order across pointer wrap.
- Push 3 entries, assert reset_n=0 for one edge while rf_write=1 -> next cycle count=0, rf_write=0; no further register-file writes occur.

Source files
------------

// File: rtl/wb_write_buffer.sv
// In-order write-back buffer feeding the register file write port, with a combinational bypass lookup.
// Optional feature: define WB_COALESCE_EN to merge a push into the youngest entry when it targets the same register.
module wb_write_buffer #(
    parameter int WORD_SIZE  = 16,
    parameter int NUM_REGS   = 4,
    parameter int REG_ADDR_W = 2,
    parameter int DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [REG_ADDR_W-1:0]      in_reg,
    input  logic [WORD_SIZE-1:0]       in_data,
    input  logic                       drain_en,
    output logic                       rf_write,
    output logic [REG_ADDR_W-1:0]      rf_write_reg,
    output logic [WORD_SIZE-1:0]       rf_write_data,
    input  logic [REG_ADDR_W-1:0]      q_reg1,
    input  logic [REG_ADDR_W-1:0]      q_reg2,
    output logic                       q_hit1,
    output logic [WORD_SIZE-1:0]       q_data1,
    output logic                       q_hit2,
    output logic [WORD_SIZE-1:0]       q_data2,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    if (REG_ADDR_W != $clog2(NUM_REGS)) begin : g_bad_addr_w
        $error("wb_write_buffer: REG_ADDR_W must equal log2(NUM_REGS)");
    end
    if (DEPTH < 2 || (1 << PTR_W) != DEPTH) begin : g_bad_depth
        $error("wb_write_buffer: DEPTH must be a power of two, at least 2");
    end

    logic [REG_ADDR_W-1:0] mem_reg  [DEPTH];
    logic [WORD_SIZE-1:0]  mem_data [DEPTH];
    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;
    logic [CNT_W-1:0]      count_q;

    logic coalesce_hit;
    logic push;
    logic alloc;
    logic merge;

    assign count    = count_q;
    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(DEPTH));
    assign rf_write = !empty && drain_en;

    assign rf_write_reg  = mem_reg[head];
    assign rf_write_data = mem_data[head];

`ifdef WB_COALESCE_EN
    logic [PTR_W-1:0] tail_prev;

    // Merging into the head while it is being committed would lose the new value, so allocate instead.
    assign tail_prev    = tail - PTR_W'(1);
    assign coalesce_hit = !empty && (mem_reg[tail_prev] == in_reg)
                          && !((tail_prev == head) && rf_write);
    assign in_ready     = !full || (in_valid && coalesce_hit);
`else
    assign coalesce_hit = 1'b0;
    assign in_ready     = !full;
`endif

    assign push  = in_valid && in_ready;
    assign alloc = push && !coalesce_hit;
    assign merge = push && coalesce_hit;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            if (alloc) begin
                tail <= tail + PTR_W'(1);
            end
            if (rf_write) begin
                head <= head + PTR_W'(1);
            end
            case ({alloc, rf_write})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage carries no reset; only occupied slots are ever observed.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            if (alloc) begin
                mem_reg[tail]  <= in_reg;
                mem_data[tail] <= in_data;
            end
`ifdef WB_COALESCE_EN
            if (merge) begin
                mem_data[tail_prev] <= in_data;
            end
`endif
        end
    end

`ifndef WB_COALESCE_EN
    logic unused_merge;
    assign unused_merge = merge;
`endif

    // Walk from oldest to youngest so a later match overrides an earlier one.
    logic [PTR_W-1:0] slot;
    always_comb begin
        slot    = '0;
        q_hit1  = 1'b0;
        q_data1 = '0;
        q_hit2  = 1'b0;
        q_data2 = '0;
        for (int k = 0; k < DEPTH; k++) begin
            slot = head + PTR_W'(k);
            if (CNT_W'(k) < count_q) begin
                if (mem_reg[slot] == q_reg1) begin
                    q_hit1  = 1'b1;
                    q_data1 = mem_data[slot];
                end
                if (mem_reg[slot] == q_reg2) begin
                    q_hit2  = 1'b1;
                    q_data2 = mem_data[slot];
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_write_buffer.sv
// Self-checking bench for wb_write_buffer: directed scenarios followed by random traffic,
// compared against a queue-based model of the pending writes.
module tb_wb_write_buffer;

    localparam int WORD_SIZE  = 16;
    localparam int NUM_REGS   = 4;
    localparam int REG_ADDR_W = 2;
    localparam int DEPTH      = 4;

    logic                  clk;
    logic                  reset_n;
    logic                  in_valid;
    logic                  in_ready;
    logic [REG_ADDR_W-1:0] in_reg;
    logic [WORD_SIZE-1:0]  in_data;
    logic                  drain_en;
    logic                  rf_write;
    logic [REG_ADDR_W-1:0] rf_write_reg;
    logic [WORD_SIZE-1:0]  rf_write_data;
    logic [REG_ADDR_W-1:0] q_reg1;
    logic [REG_ADDR_W-1:0] q_reg2;
    logic                  q_hit1;
    logic [WORD_SIZE-1:0]  q_data1;
    logic                  q_hit2;
    logic [WORD_SIZE-1:0]  q_data2;
    logic [2:0]            count;
    logic                  empty;
    logic                  full;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [REG_ADDR_W-1:0] r;
        logic [WORD_SIZE-1:0]  d;
    } ent_t;

    // Pending writes, oldest at index 0.
    ent_t mq[$];

    wb_write_buffer #(
        .WORD_SIZE (WORD_SIZE),
        .NUM_REGS  (NUM_REGS),
        .REG_ADDR_W(REG_ADDR_W),
        .DEPTH     (DEPTH)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_reg       (in_reg),
        .in_data      (in_data),
        .drain_en     (drain_en),
        .rf_write     (rf_write),
        .rf_write_reg (rf_write_reg),
        .rf_write_data(rf_write_data),
        .q_reg1       (q_reg1),
        .q_reg2       (q_reg2),
        .q_hit1       (q_hit1),
        .q_data1      (q_data1),
        .q_hit2       (q_hit2),
        .q_data2      (q_data2),
        .count        (count),
        .empty        (empty),
        .full         (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit modelCoalesce();
`ifdef WB_COALESCE_EN
        return (mq.size() > 0) && (mq[mq.size()-1].r == in_reg)
               && !((mq.size() == 1) && drain_en);
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit modelReady();
        return (mq.size() < DEPTH) || (in_valid && modelCoalesce());
    endfunction

    task automatic checkOutput();
        bit                   hit;
        logic [WORD_SIZE-1:0] val;
        chk("count", 32'(count), 32'(mq.size()));
        chk("empty", 32'(empty), 32'(mq.size() == 0));
        chk("full", 32'(full), 32'(mq.size() == DEPTH));
        chk("in_ready", 32'(in_ready), 32'(modelReady()));
        chk("rf_write", 32'(rf_write), 32'((mq.size() > 0) && drain_en));
        if (mq.size() > 0) begin
            chk("rf_write_reg", 32'(rf_write_reg), 32'(mq[0].r));
            chk("rf_write_data", 32'(rf_write_data), 32'(mq[0].d));
        end
        hit = 1'b0;
        val = '0;
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (!hit && mq[i].r == q_reg1) begin
                hit = 1'b1;
                val = mq[i].d;
            end
        end
        chk("q_hit1", 32'(q_hit1), 32'(hit));
        chk("q_data1", 32'(q_data1), 32'(val));
        hit = 1'b0;
        val = '0;
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (!hit && mq[i].r == q_reg2) begin
                hit = 1'b1;
                val = mq[i].d;
            end
        end
        chk("q_hit2", 32'(q_hit2), 32'(hit));
        chk("q_data2", 32'(q_data2), 32'(val));
    endtask

    // Checks the current cycle, advances the model by one edge, then waits for the edge.
    task automatic stepCycle();
        bit pop;
        bit push;
        bit coal;
        #3;
        checkOutput();
        pop  = (mq.size() > 0) && drain_en;
        coal = modelCoalesce();
        push = in_valid && modelReady();
        if (!reset_n) begin
            mq.delete();
        end else begin
            if (push && coal) mq[mq.size()-1].d = in_data;
            if (pop) void'(mq.pop_front());
            if (push && !coal) mq.push_back('{in_reg, in_data});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic rst_n, input logic v, input logic [REG_ADDR_W-1:0] r,
                                 input logic [WORD_SIZE-1:0] d, input logic de,
                                 input logic [REG_ADDR_W-1:0] q1, input logic [REG_ADDR_W-1:0] q2);
        reset_n  = rst_n;
        in_valid = v;
        in_reg   = r;
        in_data  = d;
        drain_en = de;
        q_reg1   = q1;
        q_reg2   = q2;
        stepCycle();
    endtask

    initial begin
        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_reg   = '0;
        in_data  = '0;
        drain_en = 1'b0;
        q_reg1   = '0;
        q_reg2   = '0;
        @(posedge clk);
        #1;

        $display("[TB] reset and idle");
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 1, 2, 3);
        chk("idle_empty", 32'(empty), 32'd1);
        chk("idle_rf_write", 32'(rf_write), 32'd0);

        $display("[TB] push two, then drain");
        applyStimulus(1, 1, 2'd1, 16'h1234, 0, 0, 0);
        applyStimulus(1, 1, 2'd2, 16'hBEEF, 0, 0, 0);
        reset_n = 1'b1; in_valid = 1'b0; drain_en = 1'b0; q_reg1 = 2'd1; q_reg2 = 2'd2;
        #3;
        chk("tp_count2", 32'(count), 32'd2);
        chk("tp_hit_r1", 32'(q_hit1), 32'd1);
        chk("tp_data_r1", 32'(q_data1), 32'h1234);
        drain_en = 1'b1;
        #1;
        chk("tp_drain1_reg", 32'(rf_write_reg), 32'd1);
        chk("tp_drain1_data", 32'(rf_write_data), 32'h1234);
        stepCycle();
        chk("tp_drain2_we", 32'(rf_write), 32'd1);
        chk("tp_drain2_data", 32'(rf_write_data), 32'hBEEF);
        stepCycle();
        chk("tp_drained_empty", 32'(empty), 32'd1);

        $display("[TB] same register twice");
        applyStimulus(1, 1, 2'd3, 16'h0001, 0, 3, 0);
        applyStimulus(1, 1, 2'd3, 16'h0002, 0, 3, 0);
        in_valid = 1'b0;
        #3;
        chk("tp_youngest", 32'(q_data1), 32'h0002);
`ifdef WB_COALESCE_EN
        chk("tp_dup_count", 32'(count), 32'd1);
`else
        chk("tp_dup_count", 32'(count), 32'd2);
`endif
        applyStimulus(1, 0, 0, 0, 1, 3, 0);
        applyStimulus(1, 0, 0, 0, 1, 3, 0);

        $display("[TB] fill, blocked push, wrap");
        for (int i = 0; i < 4; i++) applyStimulus(1, 1, 2'(i), 16'hA000 + 16'(i), 0, 2'(i), 0);
        in_valid = 1'b1; in_reg = 2'd1; in_data = 16'h5555; drain_en = 1'b0;
        #3;
        chk("tp_full", 32'(full), 32'd1);
        chk("tp_not_ready", 32'(in_ready), 32'd0);
        stepCycle();
        drain_en = 1'b1;
        stepCycle();
        chk("tp_count3", 32'(count), 32'd3);
        chk("tp_ready_again", 32'(in_ready), 32'd1);
        stepCycle();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) stepCycle();
        chk("tp_wrap_empty", 32'(empty), 32'd1);

        $display("[TB] steady push and drain");
        applyStimulus(1, 1, 2'd0, 16'h0100, 0, 0, 1);
        applyStimulus(1, 1, 2'd1, 16'h0101, 0, 0, 1);
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1, 1, 2'((k + 2) % 4), 16'h0200 + 16'(k), 1, 2'(k % 4), 2'((k + 1) % 4));
            chk("tp_steady_count", 32'(count), 32'd2);
        end
        applyStimulus(1, 0, 0, 0, 1, 0, 0);
        applyStimulus(1, 0, 0, 0, 1, 0, 0);

        $display("[TB] reset during drain");
        applyStimulus(1, 1, 2'd0, 16'h0AAA, 0, 0, 1);
        applyStimulus(1, 1, 2'd1, 16'h0BBB, 0, 0, 1);
        applyStimulus(1, 1, 2'd2, 16'h0CCC, 0, 0, 1);
        applyStimulus(0, 1, 2'd3, 16'h0DDD, 1, 0, 1);
        for (int k = 0; k < 3; k++) begin
            chk("tp_rst_count", 32'(count), 32'd0);
            chk("tp_rst_no_write", 32'(rf_write), 32'd0);
            applyStimulus(1, 0, 0, 0, 1, 0, 1);
        end

        $display("[TB] random traffic");
        for (int k = 0; k < 400; k++) begin
            applyStimulus(($urandom % 50) != 0, ($urandom % 4) != 0, 2'($urandom_range(0, 3)),
                          16'($urandom), ($urandom % 3) != 0,
                          2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
